// File: rtl/dip8_48_check.sv
// Receive-side DIP8 checker for 48-bit SL3 lane words: recomputes the diagonal
// interleaved parity, flags errored words, counts them and tracks link lock.
module dip8_48_check #(
   parameter int LOCK_GOOD  = 16,
   parameter int WINDOW     = 64,
   parameter int ERR_THRESH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             din_valid,
   input  logic [47:0]      din,
   input  logic [7:0]       din_dip,
   input  logic             clr_cnt,
   output logic             dout_valid,
   output logic [47:0]      dout,
   output logic [7:0]       dout_syndrome,
   output logic             dout_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic             locked
);

   localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
   localparam int WIN_W  = $clog2(WINDOW + 1);
   localparam int ERR_W  = $clog2(ERR_THRESH + 1);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t            state;
   logic [GOOD_W-1:0] good_run;
   logic [WIN_W-1:0]  win_cnt;
   logic [ERR_W-1:0]  win_err;

   logic [7:0]  par;
   logic        s1_valid;
   logic [47:0] s1_data;
   logic [7:0]  s1_dip;
   logic [7:0]  s1_par;
   logic [7:0]  syndrome;
   logic        word_err;

   // Each parity bit takes exactly one bit from each of the six byte rows, so
   // every bit is a single 6-input XOR.
   for (genvar k = 0; k < 8; k++) begin : g_par
      assign par[k] = din[ 0 + ((k + 1) % 8)] ^
                      din[ 8 + ((k + 2) % 8)] ^
                      din[16 + ((k + 3) % 8)] ^
                      din[24 + ((k + 4) % 8)] ^
                      din[32 + ((k + 5) % 8)] ^
                      din[40 + ((k + 6) % 8)];
   end

   assign syndrome = s1_par ^ s1_dip;
   assign word_err = dout_valid & dout_err;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_dip   <= '0;
         s1_par   <= '0;
      end else begin
         s1_valid <= din_valid;
         s1_data  <= din;
         s1_dip   <= din_dip;
         s1_par   <= par;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         dout_valid    <= 1'b0;
         dout          <= '0;
         dout_syndrome <= '0;
         dout_err      <= 1'b0;
      end else begin
         dout_valid    <= s1_valid;
         dout          <= s1_data;
         dout_syndrome <= syndrome;
         dout_err      <= s1_valid & (|syndrome);
      end
   end

   // A clear coinciding with an errored word still records that word.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else if (clr_cnt) begin
         err_cnt    <= word_err ? CNT_W'(1) : '0;
         err_sticky <= word_err;
      end else if (word_err) begin
         err_sticky <= 1'b1;
         if (err_cnt != {CNT_W{1'b1}}) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state    <= HUNT;
         locked   <= 1'b0;
         good_run <= '0;
         win_cnt  <= '0;
         win_err  <= '0;
      end else if (dout_valid) begin
         case (state)
            HUNT: begin
               if (dout_err) begin
                  good_run <= '0;
               end else if (good_run == GOOD_W'(LOCK_GOOD - 1)) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  good_run <= '0;
                  win_cnt  <= '0;
                  win_err  <= '0;
               end else begin
                  good_run <= good_run + 1'b1;
               end
            end
            LOCKED: begin
               // The threshold check wins over the window wrap on the last word.
               if (dout_err && (win_err == ERR_W'(ERR_THRESH - 1))) begin
                  state    <= HUNT;
                  locked   <= 1'b0;
                  good_run <= '0;
                  win_cnt  <= '0;
                  win_err  <= '0;
               end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                  win_cnt <= '0;
                  win_err <= '0;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
                  win_err <= win_err + ERR_W'(dout_err);
               end
            end
            default: begin
               state  <= HUNT;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dip8_48_check.sv
// Scoreboard bench for dip8_48_check: a parity model feeds an expected-word
// queue, and a cycle model tracks err_cnt, err_sticky and the lock state.
module tb_dip8_48_check;

   localparam int LOCK_GOOD  = 16;
   localparam int WINDOW     = 64;
   localparam int ERR_THRESH = 4;

   logic        clk = 1'b0;
   logic        arst;
   logic        din_valid;
   logic [47:0] din;
   logic [7:0]  din_dip;
   logic        clr_cnt;

   logic        dout_valid;
   logic [47:0] dout;
   logic [7:0]  dout_syndrome;
   logic        dout_err;
   logic        err_sticky;
   logic [15:0] err_cnt;
   logic        locked;

   logic        dout_valid4;
   logic [47:0] dout4;
   logic [7:0]  dout_syndrome4;
   logic        dout_err4;
   logic        err_sticky4;
   logic [3:0]  err_cnt4;
   logic        locked4;

   dip8_48_check #(
      .LOCK_GOOD(LOCK_GOOD), .WINDOW(WINDOW), .ERR_THRESH(ERR_THRESH), .CNT_W(16)
   ) dut (
      .clk(clk), .arst(arst), .din_valid(din_valid), .din(din), .din_dip(din_dip),
      .clr_cnt(clr_cnt), .dout_valid(dout_valid), .dout(dout),
      .dout_syndrome(dout_syndrome), .dout_err(dout_err), .err_sticky(err_sticky),
      .err_cnt(err_cnt), .locked(locked)
   );

   dip8_48_check #(
      .LOCK_GOOD(LOCK_GOOD), .WINDOW(WINDOW), .ERR_THRESH(ERR_THRESH), .CNT_W(4)
   ) dut4 (
      .clk(clk), .arst(arst), .din_valid(din_valid), .din(din), .din_dip(din_dip),
      .clr_cnt(clr_cnt), .dout_valid(dout_valid4), .dout(dout4),
      .dout_syndrome(dout_syndrome4), .dout_err(dout_err4), .err_sticky(err_sticky4),
      .err_cnt(err_cnt4), .locked(locked4)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [47:0] data;
      logic [7:0]  syn;
      logic        err;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   logic [1:0] pipeV;
   logic [1:0] pipeE;
   int         mCnt, mCnt4, mGood, mWin, mWerr;
   logic       mSticky, mLocked;

   logic [47:0] w;
   int          firstLock;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Walks the data bits and drops each one into the parity bit its diagonal
   // lands on.
   function automatic logic [7:0] refDip(input logic [47:0] d);
      logic [7:0] p;
      int k;
      p = '0;
      for (int i = 0; i < 48; i++) begin
         k = ((i % 8) - 1 - (i / 8) + 16) % 8;
         if (d[i]) p[k] = ~p[k];
      end
      return p;
   endfunction

   function automatic logic [47:0] randWord();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[47:0];
   endfunction

   task automatic resetModel();
      pipeV   = '0;
      pipeE   = '0;
      mCnt    = 0;
      mCnt4   = 0;
      mGood   = 0;
      mWin    = 0;
      mWerr   = 0;
      mSticky = 1'b0;
      mLocked = 1'b0;
      expQ.delete();
   endtask

   task automatic modelStage2(input logic v, input logic e, input logic clr);
      if (clr) begin
         mCnt    = (v && e) ? 1 : 0;
         mCnt4   = mCnt;
         mSticky = v && e;
      end else if (v && e) begin
         if (mCnt < 65535) mCnt++;
         if (mCnt4 < 15) mCnt4++;
         mSticky = 1'b1;
      end
      if (v) begin
         if (!mLocked) begin
            if (e) mGood = 0;
            else begin
               mGood++;
               if (mGood == LOCK_GOOD) begin
                  mLocked = 1'b1;
                  mGood = 0;
                  mWin = 0;
                  mWerr = 0;
               end
            end
         end else begin
            mWin++;
            if (e) mWerr++;
            if (mWerr >= ERR_THRESH) begin
               mLocked = 1'b0;
               mGood = 0;
               mWin = 0;
               mWerr = 0;
            end else if (mWin >= WINDOW) begin
               mWin = 0;
               mWerr = 0;
            end
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, advance the model, check the
   // status outputs just after the rising edge.
   task automatic applyStimulus(input logic v, input logic [47:0] d,
                                input logic [7:0] dip, input logic clr);
      logic [7:0] syn;
      @(negedge clk);
      din_valid = v;
      din       = d;
      din_dip   = dip;
      clr_cnt   = clr;
      syn = refDip(d) ^ dip;
      if (v) expQ.push_back('{data: d, syn: syn, err: (syn != 8'h00)});
      modelStage2(pipeV[1], pipeE[1], clr);
      pipeV[1] = pipeV[0];
      pipeE[1] = pipeE[0];
      pipeV[0] = v;
      pipeE[0] = v && (syn != 8'h00);
      @(posedge clk);
      #1;
      checkOutput("locked", 64'(locked), 64'(mLocked));
      checkOutput("err_cnt", 64'(err_cnt), 64'(mCnt));
      checkOutput("err_sticky", 64'(err_sticky), 64'(mSticky));
      checkOutput("locked4", 64'(locked4), 64'(mLocked));
      checkOutput("err_cnt4", 64'(err_cnt4), 64'(mCnt4));
      checkOutput("err_sticky4", 64'(err_sticky4), 64'(mSticky));
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 48'h0, 8'h00, 1'b0);
   endtask

   task automatic sendGood(input int n);
      logic [47:0] d;
      repeat (n) begin
         d = randWord();
         applyStimulus(1'b1, d, refDip(d), 1'b0);
      end
   endtask

   task automatic sendBad(input int n);
      logic [47:0] d;
      for (int i = 0; i < n; i++) begin
         d = randWord();
         applyStimulus(1'b1, d, refDip(d) ^ (8'h01 << (i % 8)), 1'b0);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (dout_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious_valid", 64'(dout_valid), 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("dout", 64'(dout), 64'(e.data));
               checkOutput("syndrome", 64'(dout_syndrome), 64'(e.syn));
               checkOutput("dout_err", 64'(dout_err), 64'(e.err));
               checkOutput("dout4", 64'(dout4), 64'(e.data));
               checkOutput("syndrome4", 64'(dout_syndrome4), 64'(e.syn));
               checkOutput("dout_err4", 64'(dout_err4), 64'(e.err));
            end
         end else begin
            checkOutput("bubble_err", 64'(dout_err), 64'd0);
            checkOutput("bubble_valid4", 64'(dout_valid4), 64'd0);
         end
      end
   end

   initial begin
      arst      = 1'b1;
      din_valid = 1'b0;
      din       = '0;
      din_dip   = '0;
      clr_cnt   = 1'b0;
      resetModel();
      #1;
      checkOutput("rst_valid", 64'(dout_valid), 64'd0);
      checkOutput("rst_locked", 64'(locked), 64'd0);
      checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
      checkOutput("rst_sticky", 64'(err_sticky), 64'd0);
      repeat (2) @(negedge clk);
      arst = 1'b0;

      // Single-bit words: bit 0 lands in p[7]; bit 47 lands in p[1].
      applyStimulus(1'b1, 48'h1, 8'h00, 1'b0);
      applyStimulus(1'b1, 48'h1, 8'h80, 1'b0);
      applyStimulus(1'b1, 48'h8000_0000_0000, 8'h00, 1'b0);
      idle(3);
      checkOutput("two_errs_cnt", 64'(err_cnt), 64'd2);

      firstLock = 0;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b1, 48'h0, 8'h00, 1'b0);
         if (locked && firstLock == 0) firstLock = i + 1;
      end
      checkOutput("lock_cycle", 64'(firstLock), 64'(LOCK_GOOD + 3));
      idle(3);

      for (int i = 0; i < 20; i++) begin
         w = randWord();
         if (i == 3 || i == 9 || i == 15) applyStimulus(1'b1, w, refDip(w) ^ 8'h10, 1'b0);
         else applyStimulus(1'b1, w, refDip(w), 1'b0);
      end
      idle(3);
      checkOutput("three_errs_locked", 64'(locked), 64'd1);
      sendBad(1);
      idle(3);
      checkOutput("fourth_err_unlocked", 64'(locked), 64'd0);

      sendGood(LOCK_GOOD);
      idle(3);
      checkOutput("relocked", 64'(locked), 64'd1);
      sendBad(2);
      sendGood(WINDOW - 2);
      sendBad(2);
      sendGood(4);
      idle(3);
      checkOutput("spread_errs_locked", 64'(locked), 64'd1);

      w = randWord();
      applyStimulus(1'b1, w, refDip(w) ^ 8'h04, 1'b0);
      applyStimulus(1'b0, 48'h0, 8'h00, 1'b0);
      applyStimulus(1'b0, 48'h0, 8'h00, 1'b1);
      checkOutput("clr_same_cycle_cnt", 64'(err_cnt), 64'd1);
      checkOutput("clr_same_cycle_sticky", 64'(err_sticky), 64'd1);
      applyStimulus(1'b0, 48'h0, 8'h00, 1'b1);
      checkOutput("clr_idle_cnt", 64'(err_cnt), 64'd0);
      checkOutput("clr_idle_sticky", 64'(err_sticky), 64'd0);

      sendBad(20);
      idle(3);
      checkOutput("sat_cnt4", 64'(err_cnt4), 64'd15);
      checkOutput("cnt16_twenty", 64'(err_cnt), 64'd20);

      sendGood(LOCK_GOOD);
      idle(3);
      w = randWord();
      applyStimulus(1'b1, w, refDip(w) ^ 8'h20, 1'b0);
      sendGood(1);
      #1;
      arst      = 1'b1;
      din_valid = 1'b0;
      clr_cnt   = 1'b0;
      resetModel();
      #1;
      checkOutput("arst_valid", 64'(dout_valid), 64'd0);
      checkOutput("arst_dout", 64'(dout), 64'd0);
      checkOutput("arst_syndrome", 64'(dout_syndrome), 64'd0);
      checkOutput("arst_err", 64'(dout_err), 64'd0);
      checkOutput("arst_sticky", 64'(err_sticky), 64'd0);
      checkOutput("arst_cnt", 64'(err_cnt), 64'd0);
      checkOutput("arst_locked", 64'(locked), 64'd0);
      @(negedge clk);
      arst = 1'b0;
      idle(5);
      sendGood(3);
      idle(3);
      checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
